// File: rtl/rom_arbiter_pkg.sv
// Shared types for the IF/LS instruction ROM arbiter.
// Port identifiers and default ROM geometry.
package rom_arbiter_pkg;

  typedef enum logic {
    ARB_PORT_IF = 1'b0,
    ARB_PORT_LS = 1'b1
  } arb_port_e;

  localparam int unsigned ROM_WORDS_DEF = 128;

endpackage

// File: rtl/rom_rsp_fifo.sv
// Per-port response FIFO with {err, data} payload.
// Output is zero while empty; pointers are registered.
module rom_rsp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  localparam int unsigned PW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_valid = (r_count != '0);
  assign w_pop   = o_valid & i_ready;
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Credits make a push into a full, non-draining FIFO impossible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(i_push && !w_pop &&
                r_count == CW'(DEPTH)));
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin sharing of the instruction ROM between IF and LS,
// with in-flight tagging and credit-limited response FIFOs.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ROM_WORDS = ROM_WORDS_DEF,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid_i,
  output logic              if_req_ready_o,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_rsp_valid_o,
  input  logic              if_rsp_ready_i,
  output logic [DATA_W-1:0] if_rsp_data_o,
  output logic              if_rsp_err_o,
  input  logic              ls_req_valid_i,
  output logic              ls_req_ready_o,
  input  logic [ADDR_W-1:0] ls_addr_i,
  output logic              ls_rsp_valid_o,
  input  logic              ls_rsp_ready_i,
  output logic [DATA_W-1:0] ls_rsp_data_o,
  output logic              ls_rsp_err_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_req_o,
  input  logic [DATA_W-1:0] rom_data_i
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  logic [CW-1:0]     r_if_cred;
  logic [CW-1:0]     r_ls_cred;
  arb_port_e         last_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic              inflt_v_q;
  arb_port_e         inflt_port_q;
  logic              inflt_err_q;

  logic              w_if_rsp_hs;
  logic              w_ls_rsp_hs;
  logic              w_if_elig;
  logic              w_ls_elig;
  logic              w_if_gnt;
  logic              w_ls_gnt;
  logic              w_gnt;
  arb_port_e         w_gnt_port;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic              w_gnt_err;
  logic              w_if_push;
  logic              w_ls_push;
  logic [DATA_W:0]   w_push_data;

  function automatic logic addr_err(
    input logic [ADDR_W-1:0] a
  );
    return (a[1:0] != 2'b00) ||
           ((a >> 2) >= ADDR_W'(ROM_WORDS));
  endfunction

  function automatic logic [CW-1:0] cred_nxt(
    input logic [CW-1:0] c,
    input logic          gnt,
    input logic          hs
  );
    case ({gnt, hs})
      2'b10:   return c - CW'(1);
      2'b01:   return c + CW'(1);
      default: return c;
    endcase
  endfunction

  assign w_if_rsp_hs = if_rsp_valid_o & if_rsp_ready_i;
  assign w_ls_rsp_hs = ls_rsp_valid_o & ls_rsp_ready_i;

  // A drain in the same cycle frees the slot the grant consumes.
  always_comb begin
    w_if_elig = !rst && if_req_valid_i &&
                (r_if_cred != '0 || w_if_rsp_hs);
    w_ls_elig = !rst && ls_req_valid_i &&
                (r_ls_cred != '0 || w_ls_rsp_hs);
    w_if_gnt  = 1'b0;
    w_ls_gnt  = 1'b0;
    case ({w_if_elig, w_ls_elig})
      2'b11: begin
        w_if_gnt = (last_q == ARB_PORT_LS);
        w_ls_gnt = (last_q == ARB_PORT_IF);
      end
      2'b10:   w_if_gnt = 1'b1;
      2'b01:   w_ls_gnt = 1'b1;
      default: ;
    endcase
    w_gnt      = w_if_gnt | w_ls_gnt;
    w_gnt_port = w_ls_gnt ? ARB_PORT_LS : ARB_PORT_IF;
    w_gnt_addr = w_ls_gnt ? ls_addr_i : if_addr_i;
    w_gnt_err  = addr_err(w_gnt_addr);
  end

  assign if_req_ready_o = w_if_gnt;
  assign ls_req_ready_o = w_ls_gnt;
  assign rom_req_o      = w_gnt;
  assign rom_addr_o     = w_gnt ? w_gnt_addr : last_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_cred    <= CW'(RSP_DEPTH);
      r_ls_cred    <= CW'(RSP_DEPTH);
      last_q       <= ARB_PORT_LS;
      last_addr_q  <= '0;
      inflt_v_q    <= 1'b0;
      inflt_port_q <= ARB_PORT_IF;
      inflt_err_q  <= 1'b0;
    end else begin
      r_if_cred <= cred_nxt(r_if_cred, w_if_gnt, w_if_rsp_hs);
      r_ls_cred <= cred_nxt(r_ls_cred, w_ls_gnt, w_ls_rsp_hs);
      inflt_v_q <= w_gnt;
      if (w_gnt) begin
        last_q       <= w_gnt_port;
        last_addr_q  <= w_gnt_addr;
        inflt_port_q <= w_gnt_port;
        inflt_err_q  <= w_gnt_err;
      end
    end
  end

  assign w_if_push = inflt_v_q &&
                     (inflt_port_q == ARB_PORT_IF);
  assign w_ls_push = inflt_v_q &&
                     (inflt_port_q == ARB_PORT_LS);
  assign w_push_data = {inflt_err_q,
                        inflt_err_q ? '0 : rom_data_i};

  rom_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     (DATA_W + 1)
  ) u_if_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_if_push),
    .i_data  (w_push_data),
    .o_valid (if_rsp_valid_o),
    .i_ready (if_rsp_ready_i),
    .o_data  ({if_rsp_err_o, if_rsp_data_o})
  );

  rom_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     (DATA_W + 1)
  ) u_ls_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_ls_push),
    .i_data  (w_push_data),
    .o_valid (ls_rsp_valid_o),
    .i_ready (ls_rsp_ready_i),
    .o_data  ({ls_rsp_err_o, ls_rsp_data_o})
  );

endmodule
